reflet_power_ctrl: RTL and testbench
====================================

# reflet_power_ctrl

Parametrised power manager for the reflet microcontroller peripheral bus. Software writes a register to stall the CPU through `cpu_enable`. Any unmasked wake source then resumes the CPU after a programmable stabilisation delay. Adds per-source wake masking, wake-cause capture, deep-sleep peripheral gating and a saturating sleep-duration counter. Sits inside `reflet_peripheral` alongside exti/timer, on the 8-bit peripheral data path.

## Interface

Parameters:
- `base_addr_size`, 15: width of `addr`.
- `base_addr`, 15'h7F40: address of register 0; registers occupy `base_addr` to `base_addr+7`.
- `nb_sources`, 4: wake source count, range 1 to 8.
- `nb_gated`, 8: gated peripheral enables, range 1 to 8.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-low.
- `enable` in 1: bus select from higher-level decode.
- `addr` in `base_addr_size`: byte address.
- `data_in` in 8: write data.
- `write_en` in 1: write strobe.
- `data_out` out 8: read data; 0 when not addressed, for the OR-bus.
- `wake_src` in `nb_sources`: level-sensitive wake requests, typically `ext_int`.
- `cpu_enable` out 1: CPU run enable.
- `periph_en` out `nb_gated`: per-peripheral enables.

## Operation

Registers (offset: name, reset value):
- 0 CTRL, 0: bit0 SLEEP (write 1 = request sleep; reads 1 while not RUN); bit1 DEEP (sticky mode bit).
- 1 WAKE_MASK, all `nb_sources` bits 1: bit i set lets `wake_src[i]` wake. Bits at and above `nb_sources` read 0.
- 2 WAKE_CAUSE, 0: masked sources high on the wake edge, captured at that edge. Write 1 to clear a bit.
- 3 WAKE_DELAY, 0: D, the stabilisation cycles.
- 4 GATE_MASK, 0: bit i set means `periph_en[i]` drops in deep sleep.
- 5 and 6 SLEEP_CNT low and high, 0: cycles spent in SLEEP, 16-bit. Saturates at 16'hFFFF. Cleared on sleep entry. Read-only.
- 7: reads 0.

A register is selected when `enable` is high and `addr` equals `base_addr + offset`.

FSM states: RUN, SLEEP, WAKE.
- RUN → SLEEP on a CTRL write with bit0 = 1 and WAKE_MASK ≠ 0.
  - If WAKE_MASK = 0, the request is ignored; this prevents deadlock.
  - On the same edge: SLEEP_CNT ← 0, and DEEP ← `data_in[1]`.
- SLEEP → WAKE when `wake_src & WAKE_MASK` ≠ 0.
  - On that edge: WAKE_CAUSE ← the masked value, and the counter is loaded with D.
- SLEEP holds otherwise; SLEEP_CNT increments each cycle.
- WAKE → RUN when the counter = 0; otherwise the counter decrements.
- Wake sources are ignored in RUN and WAKE.

Outputs:
- `cpu_enable` = (state == RUN).
- `periph_en[i]` = !(state == SLEEP && DEEP && GATE_MASK[i]). Peripherals are re-enabled on WAKE entry, so they stabilise during the delay.

## Timing

- Reset values: `cpu_enable` = 1, `periph_en` = all 1, `data_out` = 0, state = RUN.
- Sleep write sampled at edge w: `cpu_enable` low after edge w. The CPU instruction that performed the write completes.
- Wake source high at edge e (state SLEEP): state = WAKE after e, and `cpu_enable` high after edge e+D+1.
  - D = 0 gives one cycle of WAKE.
- Wake source already high at sleep entry: SLEEP lasts exactly one cycle. The wake is not lost.
- WAKE_CAUSE: a clear write on the same edge as a capture loses to the capture. Capture only happens in SLEEP, when the CPU cannot write, so the case is unreachable in practice.
- `data_out` is combinational from registers and `addr`, with zero latency.
- Reset asserted in SLEEP or WAKE: immediate RUN, all registers restored to reset values.

## Structure

- Register offsets and state encodings are localparams in the shared include `reflet_power_ctrl.vh`. `reflet_peripheral` and the firmware header generator both read it.
- One sub-module, `reflet_power_fsm`: state register, delay counter and wake detection.
  - Inputs: request, mask, D, sources.
  - Outputs: state and capture strobe.
- Register file, sleep counter and read mux stay in the top.

## Test plan

- **Reset**: `cpu_enable` = 1, `periph_en` = 8'hFF, WAKE_MASK reads 8'h0F, all other registers read 0.
- **Basic wake**: WAKE_DELAY = 5, write CTRL = 8'h01. Hold `wake_src` = 0 for 20 cycles, then pulse `wake_src[2]` for 1 cycle.
  - `cpu_enable` low for 20 + 1 + 6 cycles.
  - WAKE_CAUSE = 8'h04, SLEEP_CNT = 21.
- **Mask and deadlock guard**:
  - WAKE_MASK = 8'h01; `wake_src[3]` pulse leaves the CPU asleep; `wake_src[0]` wakes it.
  - WAKE_MASK = 0 followed by CTRL = 8'h01 leaves `cpu_enable` = 1.
- **Deep gating**: GATE_MASK = 8'hA0, CTRL = 8'h03.
  - `periph_en` = 8'h5F in SLEEP.
  - Returns to 8'hFF on the WAKE entry edge, before `cpu_enable` rises.
- **Pre-pending wake and saturation**:
  - `wake_src[0]` held high during the sleep write gives exactly 1 SLEEP cycle.
  - 70000 sleep cycles gives SLEEP_CNT = 16'hFFFF.
- **Reset mid-WAKE**: D = 200, drop `reset` at count 100. `cpu_enable` = 1 immediately and WAKE_DELAY reads 0.

Source files
------------

// File: rtl/reflet_power_ctrl_pkg.sv
// Shared register map and power-state encoding for reflet_power_ctrl.
// Also read by the peripheral decoder and the firmware header generator.
package reflet_power_ctrl_pkg;
    localparam logic [2:0] REG_CTRL       = 3'd0;
    localparam logic [2:0] REG_WAKE_MASK  = 3'd1;
    localparam logic [2:0] REG_WAKE_CAUSE = 3'd2;
    localparam logic [2:0] REG_WAKE_DELAY = 3'd3;
    localparam logic [2:0] REG_GATE_MASK  = 3'd4;
    localparam logic [2:0] REG_CNT_LO     = 3'd5;
    localparam logic [2:0] REG_CNT_HI     = 3'd6;

    typedef enum logic [1:0] {
        PWR_RUN   = 2'd0,
        PWR_SLEEP = 2'd1,
        PWR_WAKE  = 2'd2
    } pwr_state_t;
endpackage

// File: rtl/reflet_power_fsm.sv
// Run/sleep/wake sequencer: state register, stabilisation delay counter
// and masked wake detection.
module reflet_power_fsm
    import reflet_power_ctrl_pkg::*;
#(
    parameter int nb_sources = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sleep_req,
    input  logic [nb_sources-1:0] wake_mask,
    input  logic [7:0]            wake_delay,
    input  logic [nb_sources-1:0] wake_src,
    output pwr_state_t            state,
    output logic                  enter,
    output logic                  capture
);
    pwr_state_t state_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= PWR_RUN;
            cnt_q <= 8'd0;
        end else begin
            state <= state_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt_q;
        enter   = 1'b0;
        capture = 1'b0;
        case (state)
            PWR_RUN: begin
                // An empty mask would leave nothing able to wake the CPU.
                if (sleep_req && |wake_mask) begin
                    state_d = PWR_SLEEP;
                    enter   = 1'b1;
                end
            end
            PWR_SLEEP: begin
                if (|(wake_src & wake_mask)) begin
                    state_d = PWR_WAKE;
                    cnt_d   = wake_delay;
                    capture = 1'b1;
                end
            end
            PWR_WAKE: begin
                if (cnt_q == 8'd0) state_d = PWR_RUN;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = PWR_RUN;
        endcase
    end
endmodule

// File: rtl/reflet_power_ctrl.sv
// Power manager: register file, sleep-duration counter, read mux and
// peripheral gating around the run/sleep/wake sequencer.
module reflet_power_ctrl
    import reflet_power_ctrl_pkg::*;
#(
    parameter int                        base_addr_size = 15,
    parameter logic [base_addr_size-1:0] base_addr      = 15'h7F40,
    parameter int                        nb_sources     = 4,
    parameter int                        nb_gated       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic [7:0]                data_in,
    input  logic                      write_en,
    output logic [7:0]                data_out,
    input  logic [nb_sources-1:0]     wake_src,
    output logic                      cpu_enable,
    output logic [nb_gated-1:0]       periph_en
);
    logic [base_addr_size-1:0] off;
    logic                      hit, wr;
    logic [2:0]                sel;

    logic                  deep_q;
    logic [nb_sources-1:0] mask_q, cause_q;
    logic [7:0]            delay_q;
    logic [nb_gated-1:0]   gate_q;
    logic [15:0]           cnt_q;

    pwr_state_t state;
    logic       enter, capture, sleep_req;

    assign off       = addr - base_addr;
    assign hit       = enable && (off[base_addr_size-1:3] == '0);
    assign sel       = off[2:0];
    assign wr        = hit && write_en;
    assign sleep_req = wr && (sel == REG_CTRL) && data_in[0];

    reflet_power_fsm #(.nb_sources(nb_sources)) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .sleep_req  (sleep_req),
        .wake_mask  (mask_q),
        .wake_delay (delay_q),
        .wake_src   (wake_src),
        .state      (state),
        .enter      (enter),
        .capture    (capture)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deep_q  <= 1'b0;
            mask_q  <= '1;
            cause_q <= '0;
            delay_q <= 8'd0;
            gate_q  <= '0;
            cnt_q   <= 16'd0;
        end else begin
            if (enter) deep_q <= data_in[1];
            if (wr && sel == REG_WAKE_MASK)  mask_q  <= data_in[nb_sources-1:0];
            if (wr && sel == REG_WAKE_DELAY) delay_q <= data_in;
            if (wr && sel == REG_GATE_MASK)  gate_q  <= data_in[nb_gated-1:0];
            // Capture wins over a same-edge clear.
            if (capture)
                cause_q <= wake_src & mask_q;
            else if (wr && sel == REG_WAKE_CAUSE)
                cause_q <= cause_q & ~data_in[nb_sources-1:0];
            if (enter)
                cnt_q <= 16'd0;
            else if (state == PWR_SLEEP && cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    assign cpu_enable = (state == PWR_RUN);
    assign periph_en  = (state == PWR_SLEEP && deep_q) ? ~gate_q : '1;

    always_comb begin
        data_out = 8'd0;
        if (hit) begin
            case (sel)
                REG_CTRL:       data_out = {6'd0, deep_q, state != PWR_RUN};
                REG_WAKE_MASK:  data_out[nb_sources-1:0] = mask_q;
                REG_WAKE_CAUSE: data_out[nb_sources-1:0] = cause_q;
                REG_WAKE_DELAY: data_out = delay_q;
                REG_GATE_MASK:  data_out[nb_gated-1:0] = gate_q;
                REG_CNT_LO:     data_out = cnt_q[7:0];
                REG_CNT_HI:     data_out = cnt_q[15:8];
                default:        data_out = 8'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_reflet_power_ctrl.sv
// Self-checking bench for reflet_power_ctrl: directed scenarios plus
// randomized sleep/wake rounds against an arithmetic timing model.
module tb_reflet_power_ctrl;
    localparam logic [14:0] BASE = 15'h7F40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [14:0] addr = 15'd0;
    logic [7:0]  data_in = 8'd0;
    logic        write_en = 1'b0;
    logic [7:0]  data_out;
    logic [3:0]  wake_src = 4'd0;
    logic        cpu_enable;
    logic [7:0]  periph_en;

    int checks = 0;
    int failures = 0;

    reflet_power_ctrl #(
        .base_addr_size(15), .base_addr(BASE), .nb_sources(4), .nb_gated(8)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .addr(addr),
        .data_in(data_in), .write_en(write_en), .data_out(data_out),
        .wake_src(wake_src), .cpu_enable(cpu_enable), .periph_en(periph_en)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] o, input logic [7:0] v);
        enable = 1'b1; addr = BASE + 15'(o); data_in = v; write_en = 1'b1;
        step();
        enable = 1'b0; write_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] o, output logic [7:0] v);
        enable = 1'b1; addr = BASE + 15'(o);
        #1;
        v = data_out;
        enable = 1'b0;
    endtask

    // Counts cycles with cpu_enable low, starting in the cycle after the sleep
    // write: n cycles of noise, one cycle of pat, then sources idle.
    task automatic run_wake(input int n, input logic [3:0] pat,
                            input logic [3:0] noise, output int low);
        low = 0;
        for (int k = 1; k <= 400; k++) begin
            if (cpu_enable) break;
            low++;
            wake_src = (k <= n) ? noise : (k == n + 1) ? pat : 4'd0;
            step();
        end
        wake_src = 4'd0;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        checks++; if (cpu_enable !== 1'b1) begin failures++; $display("FAIL reset_cpu_en got=%b exp=1", cpu_enable); end
        checks++; if (periph_en !== 8'hFF) begin failures++; $display("FAIL reset_periph got=%h exp=ff", periph_en); end
        for (int o = 0; o < 8; o++) begin
            rd(3'(o), v);
            checks++;
            if (v !== ((o == 1) ? 8'h0F : 8'h00)) begin
                failures++; $display("FAIL reset_reg%0d got=%h exp=%h", o, v, (o == 1) ? 8'h0F : 8'h00);
            end
        end
        addr = BASE + 15'd1; enable = 1'b0; #1;
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL unselected_read got=%h exp=00", data_out); end
        step();
    endtask

    task automatic test_basic_wake();
        logic [7:0] v, lo, hi;
        int low;
        wr(3'd3, 8'd5);
        wr(3'd0, 8'h01);
        rd(3'd0, v);
        checks++; if (v !== 8'h01) begin failures++; $display("FAIL basic_ctrl_sleeping got=%h exp=01", v); end
        run_wake(20, 4'b0100, 4'd0, low);
        checks++; if (low != 27) begin failures++; $display("FAIL basic_low_cycles got=%0d exp=27", low); end
        rd(3'd2, v);
        checks++; if (v !== 8'h04) begin failures++; $display("FAIL basic_cause got=%h exp=04", v); end
        rd(3'd5, lo); rd(3'd6, hi);
        checks++; if ({hi, lo} !== 16'd21) begin failures++; $display("FAIL basic_sleep_cnt got=%0d exp=21", {hi, lo}); end
        wr(3'd2, 8'hFF);
        rd(3'd2, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL cause_clear got=%h exp=00", v); end
    endtask

    task automatic test_mask_guard();
        logic [7:0] v;
        wr(3'd3, 8'd0);
        wr(3'd1, 8'h01);
        wr(3'd0, 8'h01);
        wake_src = 4'b1000; step(); wake_src = 4'd0;
        repeat (10) step();
        checks++; if (cpu_enable !== 1'b0) begin failures++; $display("FAIL masked_src_woke got=%b exp=0", cpu_enable); end
        wake_src = 4'b0001; step(); wake_src = 4'd0;
        step();
        checks++; if (cpu_enable !== 1'b1) begin failures++; $display("FAIL unmasked_wake got=%b exp=1", cpu_enable); end
        rd(3'd2, v);
        checks++; if (v !== 8'h01) begin failures++; $display("FAIL mask_cause got=%h exp=01", v); end
        wr(3'd2, 8'hFF);
        wr(3'd1, 8'h00);
        wr(3'd0, 8'h01);
        step();
        checks++; if (cpu_enable !== 1'b1) begin failures++; $display("FAIL deadlock_guard got=%b exp=1", cpu_enable); end
        rd(3'd0, v);
        checks++; if (v[0] !== 1'b0) begin failures++; $display("FAIL deadlock_ctrl got=%h exp=bit0 0", v); end
        wr(3'd1, 8'hFF);
        rd(3'd1, v);
        checks++; if (v !== 8'h0F) begin failures++; $display("FAIL mask_width got=%h exp=0f", v); end
    endtask

    task automatic test_deep_gating();
        logic [7:0] v;
        wr(3'd3, 8'd3);
        wr(3'd4, 8'hA0);
        wr(3'd0, 8'h03);
        checks++; if (periph_en !== 8'h5F) begin failures++; $display("FAIL deep_periph got=%h exp=5f", periph_en); end
        rd(3'd0, v);
        checks++; if (v !== 8'h03) begin failures++; $display("FAIL deep_ctrl got=%h exp=03", v); end
        repeat (3) step();
        wake_src = 4'b0001; step(); wake_src = 4'd0;
        checks++; if (periph_en !== 8'hFF || cpu_enable !== 1'b0) begin
            failures++; $display("FAIL wake_entry periph=%h cpu=%b exp=ff,0", periph_en, cpu_enable);
        end
        repeat (3) step();
        checks++; if (cpu_enable !== 1'b0) begin failures++; $display("FAIL deep_early_run got=%b exp=0", cpu_enable); end
        step();
        checks++; if (cpu_enable !== 1'b1) begin failures++; $display("FAIL deep_run got=%b exp=1", cpu_enable); end
        wr(3'd2, 8'hFF);
        wr(3'd4, 8'h00);
    endtask

    task automatic test_prepending_saturation();
        logic [7:0] lo, hi;
        int low;
        wr(3'd3, 8'd0);
        wake_src = 4'b0001;
        wr(3'd0, 8'h01);
        run_wake(0, 4'b0001, 4'd0, low);
        checks++; if (low != 2) begin failures++; $display("FAIL prepend_low got=%0d exp=2", low); end
        rd(3'd5, lo); rd(3'd6, hi);
        checks++; if ({hi, lo} !== 16'd1) begin failures++; $display("FAIL prepend_cnt got=%0d exp=1", {hi, lo}); end
        wr(3'd2, 8'hFF);
        wr(3'd0, 8'h01);
        repeat (70000) step();
        rd(3'd5, lo); rd(3'd6, hi);
        checks++; if ({hi, lo} !== 16'hFFFF) begin failures++; $display("FAIL saturate got=%h exp=ffff", {hi, lo}); end
        run_wake(0, 4'b0010, 4'd0, low);
        checks++; if (low != 2) begin failures++; $display("FAIL saturate_wake got=%0d exp=2", low); end
        wr(3'd2, 8'hFF);
    endtask

    task automatic test_reset_mid_wake();
        logic [7:0] v;
        wr(3'd3, 8'd200);
        wr(3'd0, 8'h01);
        wake_src = 4'b0001; step(); wake_src = 4'd0;
        repeat (100) step();
        checks++; if (cpu_enable !== 1'b0) begin failures++; $display("FAIL mid_wake_cpu got=%b exp=0", cpu_enable); end
        reset = 1'b0;
        #1;
        checks++; if (cpu_enable !== 1'b1 || periph_en !== 8'hFF) begin
            failures++; $display("FAIL reset_in_wake cpu=%b periph=%h exp=1,ff", cpu_enable, periph_en);
        end
        rd(3'd3, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_delay got=%h exp=00", v); end
        rd(3'd1, v);
        checks++; if (v !== 8'h0F) begin failures++; $display("FAIL reset_mask got=%h exp=0f", v); end
        #1 reset = 1'b1;
        step();
    endtask

    // Model: low time = idle + 1 + D + 1, SLEEP_CNT = idle + 1,
    // cause = wake pattern & mask, gating = deep ? ~gate : all ones.
    task automatic test_random();
        logic [7:0] v, lo, hi, gate, exp_p;
        logic [3:0] mask, noise, pat;
        int n, d, low;
        logic deep;
        for (int it = 0; it < 10; it++) begin
            mask  = 4'($urandom_range(1, 15));
            noise = 4'($urandom) & ~mask;
            pat   = 4'($urandom);
            if ((pat & mask) == 4'd0) pat = pat | (mask & (~mask + 4'd1));
            n     = $urandom_range(0, 30);
            d     = $urandom_range(0, 15);
            gate  = 8'($urandom);
            deep  = 1'($urandom);
            exp_p = deep ? ~gate : 8'hFF;
            wr(3'd1, {4'd0, mask});
            wr(3'd3, 8'(d));
            wr(3'd4, gate);
            wr(3'd0, {6'd0, deep, 1'b1});
            checks++; if (periph_en !== exp_p) begin failures++; $display("FAIL rnd%0d_periph got=%h exp=%h", it, periph_en, exp_p); end
            run_wake(n, pat, noise, low);
            checks++; if (low != n + d + 2) begin failures++; $display("FAIL rnd%0d_low got=%0d exp=%0d", it, low, n + d + 2); end
            rd(3'd2, v);
            checks++; if (v !== {4'd0, pat & mask}) begin failures++; $display("FAIL rnd%0d_cause got=%h exp=%h", it, v, {4'd0, pat & mask}); end
            rd(3'd5, lo); rd(3'd6, hi);
            checks++; if ({hi, lo} !== 16'(n + 1)) begin failures++; $display("FAIL rnd%0d_cnt got=%0d exp=%0d", it, {hi, lo}, n + 1); end
            wr(3'd2, 8'hFF);
        end
    endtask

    initial begin
        #12 reset = 1'b1;
        step();
        test_reset();
        test_basic_wake();
        test_mask_guard();
        test_deep_gating();
        test_prepending_saturation();
        test_reset_mid_wake();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
